pulpino_ctrl_s_axi: RTL and testbench
=====================================

PULPINO_CTRL_S_AXI -- requirements
Module: pulpino_ctrl_s_axi

Interface
REQ-001 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width of the control slave.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 ap_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s_axi_control_awvalid/awready  in/out  1  AXI4-Lite write-address handshake; awaddr  in  C_S_AXI_ADDR_WIDTH.
REQ-006 s_axi_control_wvalid/wready  in/out  1; wdata  in  32; wstrb  in  4  byte enables.
REQ-007 s_axi_control_bvalid/bready  out/in  1; bresp  out  2  always 2'b00.
REQ-008 s_axi_control_arvalid/arready  in/out  1; araddr  in  C_S_AXI_ADDR_WIDTH.
REQ-009 s_axi_control_rvalid/rready  out/in  1; rdata  out  32; rresp  out  2  always 2'b00.
REQ-010 interrupt  out  1  level interrupt to host.
REQ-011 ap_start  out  1  kernel start level; ap_done, ap_ready, ap_idle  in  1  kernel status.
REQ-012 spi_enable  out  1; use_qspi  out  1; spi_addr_idx  out  32; instr_num  out  32; spi_data  out  64  (spi_data is the host buffer base address).

Function
REQ-013 Register map (byte offsets): 0x00 CTRL, 0x04 GIE, 0x08 IER, 0x0C ISR, 0x10 spi_enable[0], 0x18 use_qspi[0], 0x20 spi_addr_idx, 0x28 instr_num, 0x30 spi_data[31:0], 0x34 spi_data[63:32].
REQ-014 CTRL bits: 0 ap_start (RW), 1 ap_done (RO, clear-on-read), 2 ap_idle (RO), 3 ap_ready (RO), 7 auto_restart (RW); all other bits read 0.
REQ-015 Write FSM states are WRIDLE, WRDATA and WRRESP: WRIDLE asserts awready and latches awaddr on handshake, moving to WRDATA; WRDATA asserts wready and commits the write on handshake, moving to WRRESP; WRRESP asserts bvalid until bready, then returns to WRIDLE.
REQ-016 Read FSM states are RDIDLE and RDDATA: RDIDLE asserts arready; on handshake rdata is registered and the FSM enters RDDATA; RDDATA holds rvalid and a stable rdata until rready, then returns to RDIDLE.
REQ-017 Writes honour wstrb per byte; writes to unmapped or RO offsets are ignored yet still complete with an OKAY response.
REQ-018 Reads of unmapped offsets return 0; address bits [1:0] are ignored.
REQ-019 ap_start is set by a CTRL write with wdata[0]=1 and wstrb[0]=1; it clears on the cycle after ap_ready=1 unless auto_restart=1; writing 0 never clears it.
REQ-020 The ap_done flag is set by ap_done=1 and cleared by a completed read handshake at 0x00; if both occur in the same cycle, set wins and the read returns the pre-update value.
REQ-021 ap_idle and ap_ready bits reflect the inputs registered once (1-cycle latency).
REQ-022 IER[1:0] enables the done/ready interrupts; ISR[0] is set on ap_done&IER[0], and ISR[1] is set on ap_ready&IER[1].
REQ-023 Writing 1 to an ISR bit toggles it; if set and toggle coincide, set wins.
REQ-024 interrupt = GIE[0] & (ISR[0] | ISR[1]), registered.
REQ-025 Argument outputs are driven directly from their registers and change on the cycle after the write handshake; outputs are independent of ap_start state.

Reset
REQ-026 Asserting ap_rst_n low asynchronously clears all registers, flags and outputs to 0, except ap_idle bit (reset 1); both FSMs go to idle.
REQ-027 The reset state drives awready=1, arready=1, wready=0, bvalid=0, rvalid=0, interrupt=0 and ap_start=0.
REQ-028 Reset mid-transaction abandons it with no response; the host must reissue.

Structure
REQ-029 Register offsets, CTRL bit indices and FSM state enums are placed in package pulpino_ctrl_pkg.
REQ-030 The design is a single module with no submodules; both FSMs and the register file are in the same module.

Verification
REQ-031 Write 0x1234_5678 to 0x20, then read 0x20 -> spi_addr_idx=0x12345678 one cycle after bvalid, and rdata=0x12345678.
REQ-032 Write 0x30=0xDEAD_BEEF and 0x34=0x0000_0001 with wstrb=4'b0011 on the second write -> spi_data=0x0000_0001_DEAD_BEEF.
REQ-033 Write CTRL=0x1, then pulse ap_ready -> ap_start=1 and then 0 on the next cycle; with CTRL=0x81, ap_start stays 1.
REQ-034 Pulse ap_done, then read 0x00 twice -> bit1=1 on the first read and 0 on the second.
REQ-035 Set GIE=1 and IER=1, then pulse ap_done -> interrupt rises; write ISR=0x1 -> interrupt falls.
REQ-036 Hold bready=0 for 5 cycles -> bvalid is held and awready=0; drop ap_rst_n mid-read -> rvalid=0 immediately.

Source files
------------

// File: rtl/pulpino_ctrl_pkg.sv
// Shared register map, CTRL bit positions and FSM encodings for the control slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pulpino_ctrl_pkg;

  // Byte offsets of the control register map
  localparam int unsigned ADDR_CTRL         = 'h00;
  localparam int unsigned ADDR_GIE          = 'h04;
  localparam int unsigned ADDR_IER          = 'h08;
  localparam int unsigned ADDR_ISR          = 'h0C;
  localparam int unsigned ADDR_SPI_ENABLE   = 'h10;
  localparam int unsigned ADDR_USE_QSPI     = 'h18;
  localparam int unsigned ADDR_SPI_ADDR_IDX = 'h20;
  localparam int unsigned ADDR_INSTR_NUM    = 'h28;
  localparam int unsigned ADDR_SPI_DATA_LO  = 'h30;
  localparam int unsigned ADDR_SPI_DATA_HI  = 'h34;

  // CTRL register bit indices
  localparam int CTRL_AP_START     = 0;
  localparam int CTRL_AP_DONE      = 1;
  localparam int CTRL_AP_IDLE      = 2;
  localparam int CTRL_AP_READY     = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_e;
  typedef enum logic       {RDIDLE, RDDATA}         rd_state_e;

  // Merge write data into an existing 32-bit word under byte enables
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pulpino_ctrl_s_axi_if.sv
// AXI4-Lite control-slave bundle (AW, W, B, AR, R channels).
// Latency: n/a (wiring only).
// Backpressure: plain valid/ready on every channel.
interface pulpino_ctrl_s_axi_if #(
  parameter int ADDR_W = 6
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/pulpino_ctrl_s_axi.sv
// AXI4-Lite control slave: ap_ctrl handshake, interrupt logic and SPI loader arguments.
// Latency: write commits on the W handshake edge, read data registered on the AR handshake edge.
// Backpressure: one transaction in flight per direction; B and R are held until bready/rready.
module pulpino_ctrl_s_axi
  import pulpino_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  pulpino_ctrl_s_axi_if.slave  s_axi_control,
  output logic                 interrupt,
  output logic                 ap_start,
  input  logic                 ap_done,
  input  logic                 ap_ready,
  input  logic                 ap_idle,
  output logic                 spi_enable,
  output logic                 use_qspi,
  output logic [31:0]          spi_addr_idx,
  output logic [31:0]          instr_num,
  output logic [63:0]          spi_data
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  // Word-align every address: the two byte-select bits carry no meaning here
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  wr_state_e                     wstate;
  rd_state_e                     rstate;
  logic                          aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [AW-1:0]                 waddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [31:0]                   rd_val;
  logic [AW-1:0]                 raddr;
  logic                          w_hs, ar_hs, ctrl_wr, isr_wr;
  logic                          auto_restart, done_flag, idle_q, ready_q, gie;
  logic [1:0]                    ier, isr;

  assign s_axi_control.awready = aw_rdy;
  assign s_axi_control.wready  = w_rdy;
  assign s_axi_control.bvalid  = b_vld;
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = ar_rdy;
  assign s_axi_control.rvalid  = r_vld;
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = 2'b00;

  assign raddr   = s_axi_control.araddr & WORD_MASK;
  assign w_hs    = s_axi_control.wvalid & w_rdy;
  assign ar_hs   = s_axi_control.arvalid & ar_rdy;
  assign ctrl_wr = w_hs && (waddr_q == AW'(ADDR_CTRL));
  assign isr_wr  = w_hs && (waddr_q == AW'(ADDR_ISR));

  // Write channel FSM: address, then data, then hold the response until accepted
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wstate  <= WRIDLE;
      aw_rdy  <= 1'b1;
      w_rdy   <= 1'b0;
      b_vld   <= 1'b0;
      waddr_q <= '0;
    end else begin
      case (wstate)
        WRIDLE: if (s_axi_control.awvalid) begin
          waddr_q <= s_axi_control.awaddr & WORD_MASK;
          wstate  <= WRDATA;
          aw_rdy  <= 1'b0;
          w_rdy   <= 1'b1;
        end
        WRDATA: if (s_axi_control.wvalid) begin
          wstate <= WRRESP;
          w_rdy  <= 1'b0;
          b_vld  <= 1'b1;
        end
        WRRESP: if (s_axi_control.bready) begin
          wstate <= WRIDLE;
          b_vld  <= 1'b0;
          aw_rdy <= 1'b1;
        end
        default: begin
          wstate <= WRIDLE;
          aw_rdy <= 1'b1;
          w_rdy  <= 1'b0;
          b_vld  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: capture the addressed register, hold it until rready
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rstate  <= RDIDLE;
      ar_rdy  <= 1'b1;
      r_vld   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (rstate)
        RDIDLE: if (s_axi_control.arvalid) begin
          rdata_q <= rd_val;
          rstate  <= RDDATA;
          ar_rdy  <= 1'b0;
          r_vld   <= 1'b1;
        end
        RDDATA: if (s_axi_control.rready) begin
          rstate <= RDIDLE;
          r_vld  <= 1'b0;
          ar_rdy <= 1'b1;
        end
        default: begin
          rstate <= RDIDLE;
          ar_rdy <= 1'b1;
          r_vld  <= 1'b0;
        end
      endcase
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rd_val = '0;
    case (raddr)
      AW'(ADDR_CTRL): begin
        rd_val[CTRL_AP_START]     = ap_start;
        rd_val[CTRL_AP_DONE]      = done_flag;
        rd_val[CTRL_AP_IDLE]      = idle_q;
        rd_val[CTRL_AP_READY]     = ready_q;
        rd_val[CTRL_AUTO_RESTART] = auto_restart;
      end
      AW'(ADDR_GIE):          rd_val[0]   = gie;
      AW'(ADDR_IER):          rd_val[1:0] = ier;
      AW'(ADDR_ISR):          rd_val[1:0] = isr;
      AW'(ADDR_SPI_ENABLE):   rd_val[0]   = spi_enable;
      AW'(ADDR_USE_QSPI):     rd_val[0]   = use_qspi;
      AW'(ADDR_SPI_ADDR_IDX): rd_val      = spi_addr_idx;
      AW'(ADDR_INSTR_NUM):    rd_val      = instr_num;
      AW'(ADDR_SPI_DATA_LO):  rd_val      = spi_data[31:0];
      AW'(ADDR_SPI_DATA_HI):  rd_val      = spi_data[63:32];
      default:                rd_val      = '0;
    endcase
  end

  // ap_start: host sets it, kernel ap_ready retires it unless auto_restart re-arms
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
    end else begin
      if (ctrl_wr && s_axi_control.wstrb[0] && s_axi_control.wdata[0]) ap_start <= 1'b1;
      else if (ap_ready)                                                ap_start <= auto_restart;
      if (ctrl_wr && s_axi_control.wstrb[0]) auto_restart <= s_axi_control.wdata[CTRL_AUTO_RESTART];
    end
  end

  // Sticky done flag cleared by reading CTRL; a new ap_done in the same cycle wins
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                              done_flag <= 1'b0;
    else if (ap_done)                           done_flag <= 1'b1;
    else if (ar_hs && raddr == AW'(ADDR_CTRL))  done_flag <= 1'b0;
  end

  // Kernel idle/ready status sampled once for the CTRL view
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idle_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      idle_q  <= ap_idle;
      ready_q <= ap_ready;
    end
  end

  // Interrupt enables and status; a status event beats a host toggle in the same cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie <= 1'b0;
      ier <= 2'b00;
      isr <= 2'b00;
    end else begin
      if (w_hs && waddr_q == AW'(ADDR_GIE) && s_axi_control.wstrb[0]) gie <= s_axi_control.wdata[0];
      if (w_hs && waddr_q == AW'(ADDR_IER) && s_axi_control.wstrb[0]) ier <= s_axi_control.wdata[1:0];
      if (ap_done && ier[0])                         isr[0] <= 1'b1;
      else if (isr_wr && s_axi_control.wstrb[0])     isr[0] <= isr[0] ^ s_axi_control.wdata[0];
      if (ap_ready && ier[1])                        isr[1] <= 1'b1;
      else if (isr_wr && s_axi_control.wstrb[0])     isr[1] <= isr[1] ^ s_axi_control.wdata[1];
    end
  end

  // Registered level interrupt to the host
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) interrupt <= 1'b0;
    else           interrupt <= gie & (isr[0] | isr[1]);
  end

  // Loader argument registers, byte-enabled and visible the cycle after the W handshake
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      spi_enable   <= 1'b0;
      use_qspi     <= 1'b0;
      spi_addr_idx <= '0;
      instr_num    <= '0;
      spi_data     <= '0;
    end else if (w_hs) begin
      case (waddr_q)
        AW'(ADDR_SPI_ENABLE):   if (s_axi_control.wstrb[0]) spi_enable <= s_axi_control.wdata[0];
        AW'(ADDR_USE_QSPI):     if (s_axi_control.wstrb[0]) use_qspi   <= s_axi_control.wdata[0];
        AW'(ADDR_SPI_ADDR_IDX): spi_addr_idx <= apply_wstrb(spi_addr_idx, s_axi_control.wdata, s_axi_control.wstrb);
        AW'(ADDR_INSTR_NUM):    instr_num    <= apply_wstrb(instr_num, s_axi_control.wdata, s_axi_control.wstrb);
        AW'(ADDR_SPI_DATA_LO):  spi_data[31:0]  <= apply_wstrb(spi_data[31:0], s_axi_control.wdata, s_axi_control.wstrb);
        AW'(ADDR_SPI_DATA_HI):  spi_data[63:32] <= apply_wstrb(spi_data[63:32], s_axi_control.wdata, s_axi_control.wstrb);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulpino_ctrl_s_axi.sv
// Directed bench for the control slave with a read-data scoreboard.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: bready/rready are raised only after the bench has checked the held response.
module tb_pulpino_ctrl_s_axi;

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        interrupt, ap_start, spi_enable, use_qspi;
  logic        ap_done, ap_ready, ap_idle;
  logic [31:0] spi_addr_idx, instr_num;
  logic [63:0] spi_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  always #5 ap_clk = ~ap_clk;

  pulpino_ctrl_s_axi_if #(.ADDR_W(6)) s_axi_control ();

  pulpino_ctrl_s_axi #(
    .C_S_AXI_ADDR_WIDTH(6),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axi_control (s_axi_control),
    .interrupt     (interrupt),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .ap_idle       (ap_idle),
    .spi_enable    (spi_enable),
    .use_qspi      (use_qspi),
    .spi_addr_idx  (spi_addr_idx),
    .instr_num     (instr_num),
    .spi_data      (spi_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold);
    int n;
    @(negedge ap_clk);
    s_axi_control.awvalid = 1'b1;
    s_axi_control.awaddr  = a;
    n = 0;
    while (s_axi_control.awready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("aw_handshake", 64'(n < 50), 64'd1);
    @(negedge ap_clk);
    s_axi_control.awvalid = 1'b0;
    s_axi_control.wvalid  = 1'b1;
    s_axi_control.wdata   = d;
    s_axi_control.wstrb   = s;
    n = 0;
    while (s_axi_control.wready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("w_handshake", 64'(n < 50), 64'd1);
    @(negedge ap_clk);
    s_axi_control.wvalid = 1'b0;
    n = 0;
    while (s_axi_control.bvalid !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("b_valid", 64'(n < 50), 64'd1);
    check("bresp", 64'(s_axi_control.bresp), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      check("b_hold_bvalid", 64'(s_axi_control.bvalid), 64'd1);
      check("b_hold_awready", 64'(s_axi_control.awready), 64'd0);
    end
    s_axi_control.bready = 1'b1;
    @(negedge ap_clk);
    s_axi_control.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a);
    int n;
    logic [31:0] exp;
    @(negedge ap_clk);
    s_axi_control.arvalid = 1'b1;
    s_axi_control.araddr  = a;
    n = 0;
    while (s_axi_control.arready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("ar_handshake", 64'(n < 50), 64'd1);
    @(negedge ap_clk);
    s_axi_control.arvalid = 1'b0;
    n = 0;
    while (s_axi_control.rvalid !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("r_valid", 64'(n < 50), 64'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      check($sformatf("rdata@%02h", a), 64'(s_axi_control.rdata), 64'(exp));
      check("rresp", 64'(s_axi_control.rresp), 64'd0);
      @(negedge ap_clk);
      check($sformatf("rdata_held@%02h", a), 64'(s_axi_control.rdata), 64'(exp));
    end
    s_axi_control.rready = 1'b1;
    @(negedge ap_clk);
    s_axi_control.rready = 1'b0;
  endtask

  task automatic read_expect(input logic [5:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    axi_read(a);
  endtask

  initial begin
    int n;
    s_axi_control.awvalid = 1'b0;
    s_axi_control.awaddr  = '0;
    s_axi_control.wvalid  = 1'b0;
    s_axi_control.wdata   = '0;
    s_axi_control.wstrb   = '0;
    s_axi_control.bready  = 1'b0;
    s_axi_control.arvalid = 1'b0;
    s_axi_control.araddr  = '0;
    s_axi_control.rready  = 1'b0;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b1;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_awready", 64'(s_axi_control.awready), 64'd1);
    check("rst_arready", 64'(s_axi_control.arready), 64'd1);
    check("rst_wready", 64'(s_axi_control.wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_control.bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_control.rvalid), 64'd0);
    check("rst_interrupt", 64'(interrupt), 64'd0);
    check("rst_ap_start", 64'(ap_start), 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    read_expect(6'h00, 32'h0000_0004);

    // Argument registers, byte enables, address alignment, unmapped offsets
    axi_write(6'h20, 32'h1234_5678, 4'hF, 0);
    check("spi_addr_idx", 64'(spi_addr_idx), 64'h1234_5678);
    read_expect(6'h20, 32'h1234_5678);
    read_expect(6'h23, 32'h1234_5678);
    axi_write(6'h30, 32'hDEAD_BEEF, 4'hF, 0);
    axi_write(6'h34, 32'h0000_0001, 4'b0011, 0);
    check("spi_data", spi_data, 64'h0000_0001_DEAD_BEEF);
    axi_write(6'h20, 32'hAABB_CCDD, 4'b0100, 0);
    check("spi_addr_idx_strb", 64'(spi_addr_idx), 64'h12BB_5678);
    read_expect(6'h20, 32'h12BB_5678);
    axi_write(6'h28, 32'h0000_0100, 4'hF, 0);
    axi_write(6'h10, 32'h0000_0001, 4'hF, 0);
    axi_write(6'h18, 32'h0000_0001, 4'hF, 0);
    check("instr_num", 64'(instr_num), 64'h100);
    check("spi_enable", 64'(spi_enable), 64'd1);
    check("use_qspi", 64'(use_qspi), 64'd1);
    read_expect(6'h34, 32'h0000_0001);
    axi_write(6'h38, 32'hFFFF_FFFF, 4'hF, 0);
    read_expect(6'h38, 32'h0000_0000);
    read_expect(6'h3C, 32'h0000_0000);

    // ap_start retired by ap_ready
    axi_write(6'h00, 32'h0000_0001, 4'hF, 0);
    check("start_set", 64'(ap_start), 64'd1);
    @(negedge ap_clk); ap_ready = 1'b1;
    check("start_during_ready", 64'(ap_start), 64'd1);
    @(negedge ap_clk); ap_ready = 1'b0;
    check("start_after_ready", 64'(ap_start), 64'd0);

    // auto_restart keeps ap_start up; writing 0 does not clear it
    axi_write(6'h00, 32'h0000_0081, 4'hF, 0);
    @(negedge ap_clk); ap_ready = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0;
    check("start_auto_restart", 64'(ap_start), 64'd1);
    read_expect(6'h00, 32'h0000_0085);
    axi_write(6'h00, 32'h0000_0000, 4'hF, 0);
    check("start_write0", 64'(ap_start), 64'd1);
    @(negedge ap_clk); ap_ready = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0;
    check("start_cleared", 64'(ap_start), 64'd0);

    // ap_idle status follows the input
    ap_idle = 1'b0;
    repeat (2) @(negedge ap_clk);
    read_expect(6'h00, 32'h0000_0000);
    ap_idle = 1'b1;
    repeat (2) @(negedge ap_clk);

    // ap_done is sticky and clear-on-read
    @(negedge ap_clk); ap_done = 1'b1;
    @(negedge ap_clk); ap_done = 1'b0;
    read_expect(6'h00, 32'h0000_0006);
    read_expect(6'h00, 32'h0000_0004);

    // Interrupt raise and ISR toggle-to-clear
    axi_write(6'h04, 32'h0000_0001, 4'hF, 0);
    axi_write(6'h08, 32'h0000_0001, 4'hF, 0);
    check("irq_before_done", 64'(interrupt), 64'd0);
    @(negedge ap_clk); ap_done = 1'b1;
    @(negedge ap_clk); ap_done = 1'b0;
    @(negedge ap_clk);
    check("irq_raised", 64'(interrupt), 64'd1);
    read_expect(6'h0C, 32'h0000_0001);
    axi_write(6'h0C, 32'h0000_0001, 4'hF, 0);
    check("irq_cleared", 64'(interrupt), 64'd0);
    read_expect(6'h0C, 32'h0000_0000);
    @(negedge ap_clk); ap_ready = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0;
    read_expect(6'h0C, 32'h0000_0000);
    read_expect(6'h00, 32'h0000_0006);
    read_expect(6'h04, 32'h0000_0001);
    read_expect(6'h08, 32'h0000_0001);

    // Held write response blocks the next address
    axi_write(6'h28, 32'hCAFE_0001, 4'hF, 5);
    check("instr_num_held", 64'(instr_num), 64'hCAFE_0001);

    // Reset in the middle of a read
    axi_write(6'h00, 32'h0000_0001, 4'hF, 0);
    @(negedge ap_clk);
    s_axi_control.arvalid = 1'b1;
    s_axi_control.araddr  = 6'h20;
    n = 0;
    while (s_axi_control.arready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    @(negedge ap_clk);
    s_axi_control.arvalid = 1'b0;
    n = 0;
    while (s_axi_control.rvalid !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
    check("midread_rvalid", 64'(s_axi_control.rvalid), 64'd1);
    check("midread_start", 64'(ap_start), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check("arst_rvalid", 64'(s_axi_control.rvalid), 64'd0);
    check("arst_arready", 64'(s_axi_control.arready), 64'd1);
    check("arst_awready", 64'(s_axi_control.awready), 64'd1);
    check("arst_ap_start", 64'(ap_start), 64'd0);
    check("arst_spi_addr_idx", 64'(spi_addr_idx), 64'd0);
    check("arst_spi_data", spi_data, 64'd0);
    check("arst_interrupt", 64'(interrupt), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    read_expect(6'h20, 32'h0000_0000);
    read_expect(6'h00, 32'h0000_0004);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
